// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle for the register-file write-port arbiter.
// Requester A is execute writeback, requester B is load/multi-cycle writeback.
interface regfile_wb_arbiter_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter with per-requester FIFOs and hazard query.
// Define WB_ARB_RR_EN for round-robin grants; default is fixed A-over-B.
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 3
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave req,
    output logic [4:0]          Wt_addr,
    output logic [31:0]         Wt_data,
    output logic                L_S,
    input  logic [4:0]          R_addr_A,
    input  logic [4:0]          R_addr_B,
    output logic                hazard_A,
    output logic                hazard_B,
    output logic [CNT_W-1:0]    pending_cnt,
    output logic                idle
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int QW = PW + 1;

    // Index 0 is requester A, index 1 is requester B.
    logic [4:0]    q_addr [2][FIFO_DEPTH];
    logic [31:0]   q_data [2][FIFO_DEPTH];
    logic [PW-1:0] wp [2];
    logic [PW-1:0] rp [2];
    logic [QW-1:0] cnt [2];
    logic [4:0]    in_addr [2];
    logic [31:0]   in_data [2];
    logic [1:0]    in_valid;
    logic [1:0]    ready;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    nonempty;

    assign in_valid    = {req.b_valid, req.a_valid};
    assign in_addr[0]  = req.a_addr;
    assign in_addr[1]  = req.b_addr;
    assign in_data[0]  = req.a_data;
    assign in_data[1]  = req.b_data;
    assign req.a_ready = ready[0];
    assign req.b_ready = ready[1];

    // x0 writes complete the handshake but are never stored.
    always_comb begin
        nonempty = '0;
        ready    = '0;
        push     = '0;
        for (int i = 0; i < 2; i++) begin
            nonempty[i] = (cnt[i] != '0);
            ready[i]    = !rst && (cnt[i] != QW'(FIFO_DEPTH));
            push[i]     = in_valid[i] && ready[i] && (in_addr[i] != 5'd0);
        end
    end

`ifdef WB_ARB_RR_EN
    logic last_grant;

    // last_grant: 0 = A, 1 = B. Contention goes to the other side.
    always_comb begin
        pop = nonempty;
        if (nonempty == 2'b11) begin
            pop = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (|pop) begin
            last_grant <= pop[1];
        end
    end
`else
    always_comb begin
        pop = nonempty[0] ? 2'b01 : {nonempty[1], 1'b0};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    q_addr[i][wp[i]] <= in_addr[i];
                    q_data[i][wp[i]] <= in_data[i];
                    wp[i]            <= wp[i] + PW'(1);
                end
                if (pop[i]) begin
                    rp[i] <= rp[i] + PW'(1);
                end
                cnt[i] <= cnt[i] + QW'(push[i]) - QW'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            L_S     <= 1'b0;
            Wt_addr <= '0;
            Wt_data <= '0;
        end else begin
            L_S <= |pop;
            if (pop[0]) begin
                Wt_addr <= q_addr[0][rp[0]];
                Wt_data <= q_data[0][rp[0]];
            end else if (pop[1]) begin
                Wt_addr <= q_addr[1][rp[1]];
                Wt_data <= q_data[1][rp[1]];
            end
        end
    end

    // The output stage is bypassed to readers, so only queued slots count.
    always_comb begin
        hazard_A = 1'b0;
        hazard_B = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if (QW'(k) < cnt[i]) begin
                    if (q_addr[i][rp[i] + PW'(k)] == R_addr_A) hazard_A = 1'b1;
                    if (q_addr[i][rp[i] + PW'(k)] == R_addr_B) hazard_B = 1'b1;
                end
            end
        end
        if (R_addr_A == 5'd0) hazard_A = 1'b0;
        if (R_addr_B == 5'd0) hazard_B = 1'b0;
    end

    assign pending_cnt = CNT_W'(cnt[0]) + CNT_W'(cnt[1]) + CNT_W'(L_S);
    assign idle        = (pending_cnt == '0);

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (Wt_addr/Wt_data/L_S) between two writeback requesters.
  - Requester A: ALU/execute writeback.
  - Requester B: load / multi-cycle unit writeback.
- Each requester has a small FIFO; a registered output stage drives the write port.
- Hazard outputs let decode stall reads of registers with queued, uncommitted writes.

Parameters:
- FIFO_DEPTH, 2, entries per requester FIFO; power of two, minimum 2.
- CNT_W, 3, width of pending_cnt; must hold 2*FIFO_DEPTH+1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- a_valid  in  1  requester A write request.
- a_ready  out  1  A FIFO can accept.
- a_addr  in  5  A destination register.
- a_data  in  32  A write data.
- b_valid  in  1  requester B write request.
- b_ready  out  1  B FIFO can accept.
- b_addr  in  5  B destination register.
- b_data  in  32  B write data.
- Wt_addr  out  5  to register file write address.
- Wt_data  out  32  to register file write data.
- L_S  out  1  to register file write enable.
- R_addr_A  in  5  decode read address A (hazard query).
- R_addr_B  in  5  decode read address B (hazard query).
- hazard_A  out  1  R_addr_A has a queued write.
- hazard_B  out  1  R_addr_B has a queued write.
- pending_cnt  out  CNT_W  queued FIFO entries plus output stage if L_S.
- idle  out  1  both FIFOs empty and L_S low.

Behaviour:
- Reset (rst high at an edge):
  - Both FIFOs are emptied.
  - Wt_addr=0, Wt_data=0, L_S=0, pending_cnt=0.
  - a_ready=b_ready=0 while rst is high; idle=1.
  - In-flight requests are dropped; mid-operation reset discards all contents.
- Handshake:
  - A transfer occurs when x_valid&x_ready at a rising edge.
  - x_ready = !rst && (FIFO count != FIFO_DEPTH).
  - x_ready is derived from registered count only; it never depends on x_valid.
  - Requester holds addr/data stable while valid and not ready.
- x0 writes: a transfer with addr==0 is accepted (handshake completes) but not enqueued. It never raises L_S or a hazard.
- Grant: each cycle at most one FIFO head is popped into the output stage at the rising edge.
  - Default: A has fixed priority over B.
  - B is granted only when A is empty.
- Output stage:
  - L_S=1 with that entry's Wt_addr/Wt_data for exactly one cycle per popped entry.
  - L_S=0 when nothing is popped. Wt_addr/Wt_data then hold their last value.
- Latency:
  - Request accepted at edge E0, FIFO empty, no competing grant: L_S high in the cycle after E1.
  - The register file commits at E2, i.e. 2 cycles.
  - Throughput is 1 write/cycle sustained.
- Simultaneous push/pop on the same FIFO in one cycle is legal. Count is unchanged and order is preserved.
- Ordering:
  - Per-requester FIFO order is preserved.
  - Across requesters, commit order equals grant order.
  - Requesters are responsible for not issuing conflicting writes to one register.
- Hazard:
  - hazard_X=1 iff R_addr_X!=0 and it matches addr of any valid entry in either FIFO.
  - The output stage is excluded because register file reads see write-port data during the write cycle.
  - Purely combinational from FIFO state.
- pending_cnt = countA + countB + L_S.
- idle = (pending_cnt==0).

Optional Feature:
- Macro: WB_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last_grant register (reset = B, so A wins first contention) alternates grants when both FIFOs are non-empty.
  - With only one FIFO non-empty, that FIFO is granted and last_grant updates.
- Undefined: fixed A-over-B priority as above. No last_grant register exists.

Test Plan:
- Single write: after reset, A pushes addr=5, data=0xDEADBEEF → L_S=1, Wt_addr=5, Wt_data=0xDEADBEEF exactly 2 cycles after acceptance, one cycle wide; idle returns to 1.
- Contention: A and B both push every cycle for 4 cycles (A addr 1..4, B addr 11..14) → default: commits 1,2,3,4 then 11..14. With WB_ARB_RR_EN: 1,11,2,12,3,13,4,14. b_ready drops to 0 when B holds 2 entries.
- Backpressure: B pushes 3 back-to-back while A streams continuously → b_ready=0 after 2 accepted. The third B is held until A stops, then accepted. No data lost or duplicated.
- Hazard: B pushes addr=7 while A streams; R_addr_A=7 → hazard_A=1 until the cycle L_S drives Wt_addr=7, then 0. R_addr_B=0 → hazard_B always 0.
- x0 drop: A pushes addr=0, data=0x1234 → a_ready handshake completes, L_S stays 0, pending_cnt stays 0.
- Reset mid-op: fill both FIFOs (pending_cnt=4), assert rst one cycle → next cycle L_S=0, pending_cnt=0, hazards 0, ready=1 after rst falls, and no stale write ever appears.
